// File: rtl/axis_lrelu_user_sequencer.sv
// axis_lrelu_user_sequencer
//   Sits between the conv-core output stream and axis_lrelu_engine. Per layer it
//   accepts one descriptor, then tags each beat with the LReLU/maxpool tuser
//   fields: first the engine config beats, then the raster data beats. tdata is
//   a zero-latency pass-through; only tuser, tlast and handshake gating are
//   generated here.
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   cfg_*                  layer descriptor (valid/ready handshake, accepted in IDLE only)
//   s_axis_*               conv-core output stream (tlast is checked, never forwarded)
//   m_axis_*               stream to the engine with generated tuser/tlast
//   busy                   state is not IDLE
//   err_last               sticky: upstream tlast disagreed with generated tlast
module axis_lrelu_user_sequencer #(
    parameter int unsigned DATA_WIDTH        = 256,
    parameter int unsigned BITS_CONV_CORE    = 3,
    parameter int unsigned DIM_BITS          = 10,
    parameter int unsigned PASS_BITS         = 8,
    parameter int unsigned CONFIG_BEATS_3X3  = 21,
    parameter int unsigned CONFIG_BEATS_1X1  = 13,
    parameter int unsigned TUSER_WIDTH_LRELU = BITS_CONV_CORE + 8
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_is_3x3,
    input  logic                         cfg_lrelu,
    input  logic                         cfg_maxpool,
    input  logic [DIM_BITS-1:0]          cfg_h_1,
    input  logic [DIM_BITS-1:0]          cfg_w_1,
    input  logic [PASS_BITS-1:0]         cfg_passes_1,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [BITS_CONV_CORE-1:0]    s_axis_tuser,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [TUSER_WIDTH_LRELU-1:0] m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic                         err_last
);

    localparam int unsigned CfgMax =
        (CONFIG_BEATS_3X3 > CONFIG_BEATS_1X1) ? CONFIG_BEATS_3X3 : CONFIG_BEATS_1X1;
    localparam int unsigned CfgCntW = (CfgMax > 1) ? $clog2(CfgMax) : 1;

    typedef enum logic [1:0] {StIdle, StConfig, StData} state_e;

    state_e                 state_q, state_d;
    logic [CfgCntW-1:0]     cfg_cnt_q, cfg_cnt_d;
    logic [DIM_BITS-1:0]    row_q, row_d, col_q, col_d;
    logic [PASS_BITS-1:0]   pass_q, pass_d;
    logic                   is_3x3_q, lrelu_q, maxpool_q;
    logic [DIM_BITS-1:0]    h_1_q, w_1_q;
    logic [PASS_BITS-1:0]   passes_1_q;
    logic                   err_last_q, err_last_d;

    logic cfg_hs, out_hs;
    logic row_last, col_last;
    logic [7:0] flags;

    assign busy          = (state_q != StIdle);
    assign cfg_ready     = (state_q == StIdle) && !areset;
    assign cfg_hs        = cfg_valid && cfg_ready;
    assign m_axis_tvalid = s_axis_tvalid && busy;
    assign s_axis_tready = m_axis_tready && busy;
    assign out_hs        = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign err_last      = err_last_q;

    assign row_last = (row_q == h_1_q);
    assign col_last = (col_q == w_1_q);

    assign m_axis_tlast = (state_q == StData) && row_last && col_last && (pass_q == passes_1_q);

    // Upper tuser byte; only is_3x3 is meaningful during config beats.
    always_comb begin
        flags = 8'd0;
        if (state_q == StConfig) begin
            flags[0] = is_3x3_q;
        end else if (state_q == StData) begin
            flags[0] = is_3x3_q;
            flags[1] = maxpool_q && row_q[0] && col_q[0];
            flags[2] = maxpool_q && !(row_q[0] && col_q[0]);
            flags[3] = lrelu_q;
            flags[4] = (row_q == '0);
            flags[5] = row_last;
            flags[6] = (col_q == '0);
            flags[7] = col_last;
        end
    end

    assign m_axis_tuser = {flags, s_axis_tuser};

    always_comb begin
        state_d    = state_q;
        cfg_cnt_d  = cfg_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        pass_d     = pass_q;
        err_last_d = err_last_q;

        if (out_hs && (s_axis_tlast != m_axis_tlast)) begin
            err_last_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    state_d   = StConfig;
                    cfg_cnt_d = cfg_is_3x3 ? CfgCntW'(CONFIG_BEATS_3X3 - 1)
                                           : CfgCntW'(CONFIG_BEATS_1X1 - 1);
                    row_d     = '0;
                    col_d     = '0;
                    pass_d    = '0;
                end
            end
            StConfig: begin
                if (out_hs) begin
                    if (cfg_cnt_q == '0) begin
                        state_d = StData;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q - 1'b1;
                    end
                end
            end
            StData: begin
                if (out_hs) begin
                    if (m_axis_tlast) begin
                        state_d = StIdle;
                    end
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d  = '0;
                            pass_d = pass_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            cfg_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            pass_q     <= '0;
            is_3x3_q   <= 1'b0;
            lrelu_q    <= 1'b0;
            maxpool_q  <= 1'b0;
            h_1_q      <= '0;
            w_1_q      <= '0;
            passes_1_q <= '0;
            err_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_cnt_q  <= cfg_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pass_q     <= pass_d;
            err_last_q <= err_last_d;
            if (cfg_hs) begin
                is_3x3_q   <= cfg_is_3x3;
                lrelu_q    <= cfg_lrelu;
                maxpool_q  <= cfg_maxpool;
                h_1_q      <= cfg_h_1;
                w_1_q      <= cfg_w_1;
                passes_1_q <= cfg_passes_1;
            end
        end
    end

endmodule

// File: tb/tb_axis_lrelu_user_sequencer.sv
// Testbench for axis_lrelu_user_sequencer: a reference model pushes the expected
// tuser flags/tlast of every beat of a layer into a queue; each output handshake
// pops and compares.
module tb_axis_lrelu_user_sequencer;

    localparam int DW = 256;
    localparam int B  = 3;
    localparam int DB = 10;
    localparam int PB = 8;
    localparam int TW = B + 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cfg_valid, cfg_ready, cfg_is_3x3, cfg_lrelu, cfg_maxpool;
    logic [DB-1:0] cfg_h_1, cfg_w_1;
    logic [PB-1:0] cfg_passes_1;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic [B-1:0]  s_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [TW-1:0] m_axis_tuser;
    logic          busy, err_last;

    always #5 aclk = ~aclk;

    axis_lrelu_user_sequencer dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_is_3x3    (cfg_is_3x3),
        .cfg_lrelu     (cfg_lrelu),
        .cfg_maxpool   (cfg_maxpool),
        .cfg_h_1       (cfg_h_1),
        .cfg_w_1       (cfg_w_1),
        .cfg_passes_1  (cfg_passes_1),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .err_last      (err_last)
    );

    typedef struct {
        logic [7:0] flags;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    bit   exp_err = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: full beat sequence of one layer.
    task automatic build(input bit is3, input bit lr, input bit mp,
                         input int h1, input int w1, input int p1);
        exp_t e;
        int   n = is3 ? 21 : 13;
        for (int i = 0; i < n; i++) begin
            e.flags = {7'd0, is3};
            e.last  = 1'b0;
            q.push_back(e);
        end
        for (int p = 0; p <= p1; p++) begin
            for (int r = 0; r <= h1; r++) begin
                for (int c = 0; c <= w1; c++) begin
                    bit odd = (r % 2 == 1) && (c % 2 == 1);
                    e.flags = {c == w1, c == 0, r == h1, r == 0, lr, mp && !odd, mp && odd, is3};
                    e.last  = (p == p1) && (r == h1) && (c == w1);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Entered and left at a negedge. keep: hold cfg_valid high throughout;
    // inj: beat index with a wrong s_axis_tlast; abort_at: beat index at which to reset.
    task automatic run_layer(input bit is3, input bit lr, input bit mp,
                             input int h1, input int w1, input int p1,
                             input bit rnd, input bit keep, input int inj, input int abort_at);
        int   beat = 0;
        int   cyc  = 0;
        exp_t e;
        build(is3, lr, mp, h1, w1, p1);
        cfg_valid    = 1'b1;
        cfg_is_3x3   = is3;
        cfg_lrelu    = lr;
        cfg_maxpool  = mp;
        cfg_h_1      = DB'(h1);
        cfg_w_1      = DB'(w1);
        cfg_passes_1 = PB'(p1);
        #1;
        check("cfg_ready_idle", cfg_ready, 1'b1);
        check("busy_idle", busy, 1'b0);
        @(posedge aclk);
        @(negedge aclk);
        if (keep) cfg_is_3x3 = ~is3;
        else      cfg_valid  = 1'b0;
        while (q.size() > 0 && cyc < 5000) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {8{$urandom}};
            s_axis_tuser  = B'($urandom);
            e             = q[0];
            s_axis_tlast  = e.last ^ (beat == inj);
            if (beat == abort_at) begin
                areset        = 1'b1;
                m_axis_tready = 1'b0;
                @(posedge aclk);
                @(negedge aclk);
                areset = 1'b0;
                #1;
                check("abort_busy", busy, 1'b0);
                check("abort_tvalid", m_axis_tvalid, 1'b0);
                check("abort_err", err_last, 1'b0);
                exp_err = 1'b0;
                q.delete();
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                @(negedge aclk);
                return;
            end
            #1;
            check("s_tready_mirror", s_axis_tready, m_axis_tready);
            check("tvalid", m_axis_tvalid, 1'b1);
            check("busy", busy, 1'b1);
            check("err_last", err_last, exp_err);
            if (keep) check("cfg_ready_busy", cfg_ready, 1'b0);
            if (m_axis_tready) begin
                check($sformatf("tuser[%0d]", beat), m_axis_tuser, {e.flags, s_axis_tuser});
                check($sformatf("tlast[%0d]", beat), m_axis_tlast, e.last);
                check("tdata", m_axis_tdata, s_axis_tdata);
                void'(q.pop_front());
                if (beat == inj) exp_err = 1'b1;
                beat++;
            end
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
        end
        if (cyc >= 5000) check("timeout", 1'b0, 1'b1);
        q.delete();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        check("busy_end", busy, 1'b0);
        check("cfg_ready_end", cfg_ready, 1'b1);
        check("err_end", err_last, exp_err);
    endtask

    initial begin
        areset        = 1'b1;
        cfg_valid     = 1'b0;
        cfg_is_3x3    = 1'b0;
        cfg_lrelu     = 1'b0;
        cfg_maxpool   = 1'b0;
        cfg_h_1       = '0;
        cfg_w_1       = '0;
        cfg_passes_1  = '0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_cfg_ready", cfg_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_flags", m_axis_tuser[TW-1:B], 8'd0);
        check("rst_err", err_last, 1'b0);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_cfg_ready", cfg_ready, 1'b1);
        check("idle_tvalid", m_axis_tvalid, 1'b0);
        s_axis_tvalid = 1'b0;

        // Scenario 1: 1x1, 2x2, one pass, lrelu.
        run_layer(1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, -1, -1);
        // Scenario 2: 3x3, 4x4, two passes, maxpool.
        run_layer(1'b1, 1'b0, 1'b1, 3, 3, 1, 1'b0, 1'b0, -1, -1);
        // Scenario 2 under random backpressure.
        run_layer(1'b1, 1'b0, 1'b1, 3, 3, 1, 1'b1, 1'b0, -1, -1);
        // Degenerate 1-wide/1-high image.
        run_layer(1'b0, 1'b0, 1'b1, 0, 0, 2, 1'b1, 1'b0, -1, -1);
        // Wrong upstream tlast on config beat 5.
        run_layer(1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, 4, -1);
        // cfg_valid held through a layer; next descriptor accepted right after tlast.
        run_layer(1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b1, 1'b1, -1, -1);
        run_layer(1'b1, 1'b1, 1'b1, 1, 2, 0, 1'b0, 1'b0, -1, -1);
        // Reset at data beat 2, then a fresh layer.
        run_layer(1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, -1, 14);
        run_layer(1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_lrelu_user_sequencer.md
Name: axis_lrelu_user_sequencer

Overview:
- Sits between the conv-core output stream and axis_lrelu_engine.
- Per layer, accepts one descriptor, then tags every beat with the LReLU/maxpool tuser fields and generates tlast at layer end:
  - first the engine's config beats,
  - then the data beats, with position and pool flags from raster counters.
- Data passes through with zero latency; only tuser, tlast and the handshake gating are generated.

Parameters:
- DATA_WIDTH, 256, width of tdata passed through.
- BITS_CONV_CORE, 3, width of the core-index field; it passes through in tuser[BITS_CONV_CORE-1:0].
- DIM_BITS, 10, width of the height and width fields.
- PASS_BITS, 8, width of the pass-count field.
- CONFIG_BEATS_3X3, 21, number of config beats for a 3x3 layer.
- CONFIG_BEATS_1X1, 13, number of config beats for a 1x1 layer.
- TUSER_WIDTH_LRELU, BITS_CONV_CORE+8, width of the output tuser.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  layer descriptor valid.
- cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready.
- cfg_is_3x3  in  1  kernel is 3x3 (else 1x1).
- cfg_lrelu  in  1  apply LReLU.
- cfg_maxpool  in  1  2x2 maxpool enabled.
- cfg_h_1  in  DIM_BITS  image height minus 1.
- cfg_w_1  in  DIM_BITS  image width minus 1.
- cfg_passes_1  in  PASS_BITS  number of raster passes minus 1.
- s_axis_tvalid  in  1  conv-core output valid.
- s_axis_tready  out  1  conv-core output ready.
- s_axis_tdata  in  DATA_WIDTH  conv-core output data.
- s_axis_tuser  in  BITS_CONV_CORE  core index.
- s_axis_tlast  in  1  upstream tlast; checked only, never forwarded.
- m_axis_tvalid  out  1  to the engine.
- m_axis_tready  in  1  from the engine.
- m_axis_tdata  out  DATA_WIDTH  equals s_axis_tdata.
- m_axis_tuser  out  TUSER_WIDTH_LRELU  generated flags.
- m_axis_tlast  out  1  last beat of the layer.
- busy  out  1  high when state is not IDLE.
- err_last  out  1  sticky tlast-mismatch flag.

Behaviour:
- Descriptor register:
  - Captured on the cfg handshake.
  - cfg_ready is 1 only in IDLE.
  - cfg inputs are ignored in all other states.
- States: IDLE, CONFIG, DATA.
  - IDLE -> CONFIG on the cfg handshake. At the same time: cfg_cnt <= (is_3x3 ? CONFIG_BEATS_3X3 : CONFIG_BEATS_1X1) - 1, and row, col, pass <= 0.
  - CONFIG -> DATA on the output handshake when cfg_cnt == 0. Otherwise cfg_cnt decrements on each output handshake.
  - DATA -> IDLE on the output handshake of the layer's final beat.
  - The first descriptor after the last beat is accepted no earlier than the following cycle.
- Handshake, combinational:
  - m_axis_tvalid = s_axis_tvalid && state != IDLE.
  - s_axis_tready = m_axis_tready && state != IDLE.
  - Nothing is stored. In IDLE both sides are blocked.
  - Output handshake is m_axis_tvalid && m_axis_tready.
- Counters advance only on the output handshake, in DATA:
  - col increments.
  - At col == w_1: col <= 0 and row increments.
  - At row == h_1 and col == w_1: row <= 0 and pass increments.
- Output tuser bit map (B = BITS_CONV_CORE):
  - [B-1:0] = s_axis_tuser.
  - B+0 is_3x3: the descriptor value, in both CONFIG and DATA.
  - In CONFIG, bits B+1..B+7 are 0.
  - In DATA:
    - B+1 maxpool_is_max = maxpool && row[0] && col[0].
    - B+2 maxpool_is_not_max = maxpool && !(row[0] && col[0]).
    - B+3 lrelu = descriptor lrelu bit.
    - B+4 top = (row == 0).
    - B+5 bottom = (row == h_1).
    - B+6 left = (col == 0).
    - B+7 right = (col == w_1).
  - When h_1 == 0, top and bottom are both 1. The same applies to left/right when w_1 == 0.
- m_axis_tlast = (state == DATA) && row == h_1 && col == w_1 && pass == passes_1. It is never asserted in CONFIG.
- err_last:
  - Set on any output handshake where s_axis_tlast != m_axis_tlast.
  - Cleared only by areset.
  - It does not alter sequencing.
- Backpressure: while m_axis_tready = 0, all counters and the state hold, and the outputs stay stable for a held beat.
- Reset:
  - Takes effect on a rising aclk with areset = 1.
  - Sets state IDLE, all counters and descriptor fields 0, err_last 0.
  - Reset values of outputs: cfg_ready = 0 during reset and 1 after; busy = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tuser data flags 0.
  - Reset mid-layer abandons the layer. No tlast is emitted for it.

Test Plan:
- 1x1 layer, h_1=1, w_1=1, passes_1=0, lrelu=1, maxpool=0, tready=1:
  - 13 beats with tuser[B+7:B] = 0 (is_3x3 = 0).
  - Then 4 data beats with [top,bottom,left,right] = 1010, 1001, 0110, 0101, each with lrelu bit 1.
  - tlast only on beat 17. Then busy = 0 and cfg_ready = 1.
- 3x3 layer, h_1=3, w_1=3, maxpool=1, passes_1=1:
  - 21 config beats with is_3x3 = 1.
  - Then 32 data beats. Beat at (1,1) has max=1, not_max=0. Beat (0,0) has max=0, not_max=1.
  - tlast only at beat 53.
- Random m_axis_tready (~50%) on scenario 2: identical tuser/tlast sequence, no beat lost or duplicated, s_axis_tready mirrors m_axis_tready.
- cfg_valid held high during DATA:
  - cfg_ready stays 0 until the cycle after the tlast handshake.
  - The new descriptor is accepted then, and the first config beat reflects the new is_3x3.
- Drive s_axis_tlast = 1 on config beat 5: err_last rises the next cycle and stays high; sequencing unchanged.
- Assert areset at data beat 2 of scenario 1:
  - Next cycle: busy = 0, m_axis_tvalid = 0, err_last = 0.
  - A fresh descriptor restarts with 13 config beats.
